// File: rtl/dreg_pipe_if.sv
// Handshake bundle for dreg_pipe: upstream valid/ready/data, downstream valid/ready/data.
// The occupancy signal exists only when DREG_PIPE_OCC_EN is defined.
interface dreg_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DREG_PIPE_OCC_EN
    logic [OCC_W-1:0] occupancy;
`endif

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
`ifdef DREG_PIPE_OCC_EN
        , output occupancy
`endif
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
`ifdef DREG_PIPE_OCC_EN
        , input occupancy
`endif
    );
endinterface

// File: rtl/dreg_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with bubble collapse and synchronous clear.
// Optional registered occupancy counter when DREG_PIPE_OCC_EN is defined.
module dreg_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic         clk,
    input  logic         clr,
    dreg_pipe_if.slave   bus
);
    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d     [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];

    // Stage i is ready if it or any stage downstream is empty, or the consumer takes a beat.
    always_comb begin : ready_chain
        logic w_any;
        w_any = bus.out_ready;
        w_rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_any                = w_any | ~r_v[DEPTH-1-k];
            w_rdy[DEPTH-1-k]     = w_any;
        end
    end

    always_comb begin : source_select
        w_src_v[0] = bus.in_valid;
        w_src_d[0] = bus.in_data;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_d[k] = r_d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_v <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_src_v[k];
                    if (w_src_v[k]) begin
                        r_d[k] <= w_src_d[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_v[DEPTH-1];
    assign bus.out_data  = r_d[DEPTH-1];

`ifdef DREG_PIPE_OCC_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic             w_acc;
    logic             w_del;
    logic [OCC_W-1:0] r_occ;

    assign w_acc = bus.in_valid & w_rdy[0];
    assign w_del = r_v[DEPTH-1] & bus.out_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_occ <= '0;
        end else if (w_acc && !w_del) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (w_del && !w_acc) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign bus.occupancy = r_occ;
`endif
endmodule

// File: tb/tb_dreg_pipe.sv
// Bench for dreg_pipe: directed scenarios then random traffic, checked against a beat-queue model
// where each beat's arrival at the output is max(accept + DEPTH-1, departure of the beat ahead).
module tb_dreg_pipe;
    localparam int unsigned WIDTH = 8;
    parameter  int unsigned DEPTH = 3;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    dreg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    dreg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        int unsigned      acc;
    } beat_t;

    beat_t            q[$];
    logic [WIDTH-1:0] last_data = '0;
    int unsigned      last_dep  = 0;
    int unsigned      edge_n    = 0;
    bit               known     = 1'b0;
    int unsigned      n_total   = 0;
    int unsigned      n_pass    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    endtask

    function automatic bit front_valid();
        int unsigned arr;
        if (q.size() == 0) return 1'b0;
        arr = q[0].acc + DEPTH - 1;
        if (last_dep > arr) arr = last_dep;
        return arr <= edge_n;
    endfunction

    // One clock cycle: drive on negedge, check settled outputs, then advance the model at posedge.
    task automatic step(input logic c, input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        bit e_valid, e_ready, acc, del;
        @(negedge clk);
        clr           = c;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        e_valid = front_valid();
        e_ready = ordy || (q.size() < DEPTH);
        if (known) begin
            chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
            chk("in_ready",  32'(bus.in_ready),  32'(e_ready));
            chk("out_data",  32'(bus.out_data),  32'(e_valid ? q[0].d : last_data));
`ifdef DREG_PIPE_OCC_EN
            chk("occupancy", 32'(bus.occupancy), q.size());
`endif
        end
        del = e_valid && ordy;
        acc = iv && e_ready;
        @(posedge clk);
        edge_n++;
        if (c) begin
            q.delete();
            last_data = '0;
            last_dep  = 0;
            known     = 1'b1;
        end else begin
            if (del) begin
                last_data = q[0].d;
                void'(q.pop_front());
                last_dep = edge_n;
            end
            if (acc) begin
                q.push_back('{d: id, acc: edge_n});
            end
        end
    endtask

    task automatic idle(input int unsigned n, input logic ordy);
        for (int unsigned k = 0; k < n; k++) step(1'b0, 1'b0, '0, ordy);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset: state after one clr edge
        step(1'b1, 1'b0, '0, 1'b1);
        idle(1, 1'b1);

        // Streaming at full rate
        step(1'b0, 1'b1, 8'h11, 1'b1);
        step(1'b0, 1'b1, 8'h22, 1'b1);
        step(1'b0, 1'b1, 8'h33, 1'b1);
        idle(DEPTH + 3, 1'b1);

        // Backpressure: fill, stall the fourth beat, then drain
        step(1'b0, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b1, 8'hA2, 1'b0);
        step(1'b0, 1'b1, 8'hA3, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b0);
        step(1'b0, 1'b1, 8'hA4, 1'b1);
        idle(DEPTH + 4, 1'b1);

        // Bubble collapse under a stalled consumer
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 8'h5B, 1'b0);
        idle(2, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Full pipe with simultaneous accept and deliver
        step(1'b0, 1'b1, 8'hB1, 1'b0);
        step(1'b0, 1'b1, 8'hB2, 1'b0);
        step(1'b0, 1'b1, 8'hB3, 1'b0);
        idle(DEPTH, 1'b0);
        step(1'b0, 1'b1, 8'hC0, 1'b1);
        idle(2, 1'b0);
        idle(DEPTH + 3, 1'b1);

        // Clear with beats in flight and a beat offered in the same cycle
        step(1'b0, 1'b1, 8'hD1, 1'b1);
        step(1'b0, 1'b1, 8'hD2, 1'b1);
        step(1'b1, 1'b1, 8'hD3, 1'b1);
        idle(DEPTH + 3, 1'b1);

        // Random traffic with occasional clears
        for (int unsigned k = 0; k < 600; k++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < 65),
                 WIDTH'($urandom),
                 ($urandom_range(0, 99) < 55));
        end
        idle(DEPTH + 4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
